// File: rtl/fir_stim_gen.sv
// Purpose : stimulus generator and response signature unit for a FIR filter under test.
// Latency : x_out/x_valid follow the state combinationally; y_in is captured DUT_LATENCY cycles after each x_valid.
// Backpressure: none; the filter under test must accept one sample per cycle while x_valid is high.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             run request, honoured only in IDLE
//   x_out, x_valid    Q1.15 stimulus sample and its qualifier
//   y_in              Q1.15 filter response, sampled only while cap_en is high
//   busy, done        run in progress / one-cycle end-of-run pulse
//   signature         rotate-and-XOR fold of the captured responses
//   capture_count     number of responses folded into signature
//
// Sequence per run: 1 impulse, N_TAPS-1 zeros, N_RANDOM LFSR samples, then
// DUT_LATENCY idle cycles to collect the tail, then a done pulse.
// Assumes N_TAPS >= 2, N_RANDOM >= 1, DUT_LATENCY >= 1.
module fir_stim_gen #(
    parameter int          N_TAPS      = 16,
    parameter int          DUT_LATENCY = 8,
    parameter int          N_RANDOM    = 30,
    parameter int          IMPULSE_AMP = 16384,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic signed [15:0] x_out,
    output logic               x_valid,
    input  logic signed [15:0] y_in,
    output logic               busy,
    output logic               done,
    output logic [31:0]        signature,
    output logic [7:0]         capture_count
);

    // The longest phase decides the counter width, so it never wraps inside a phase.
    localparam int MAX_A   = (N_TAPS > N_RANDOM) ? N_TAPS : N_RANDOM;
    localparam int MAX_LEN = (MAX_A > DUT_LATENCY) ? MAX_A : DUT_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int LAT     = DUT_LATENCY;

    typedef enum logic [2:0] {
        IDLE,
        IMPULSE,
        ZERO,
        RANDOM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        lfsr;
    logic [LAT-1:0]     cap_sr;
    logic               cap_en;
    logic               accept;

    // Galois form, shift right, taps 0xB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign accept = (state == IDLE) && start;
    assign cap_en = cap_sr[LAT-1];

    // Next state and Moore outputs.
    always_comb begin
        state_nxt = state;
        x_out     = '0;
        x_valid   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = IMPULSE;
            end
            IMPULSE: begin
                x_out     = 16'(IMPULSE_AMP);
                x_valid   = 1'b1;
                busy      = 1'b1;
                state_nxt = ZERO;
            end
            ZERO: begin
                x_valid = 1'b1;
                busy    = 1'b1;
                if (cnt == CNT_W'(N_TAPS - 2)) state_nxt = RANDOM;
            end
            RANDOM: begin
                x_out   = lfsr;
                x_valid = 1'b1;
                busy    = 1'b1;
                if (cnt == CNT_W'(N_RANDOM - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(DUT_LATENCY - 1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Phase-relative counter: restarts on every state change, parked in IDLE.
            if ((state_nxt != state) || (state == IDLE)) cnt <= '0;
            else                                          cnt <= cnt + 1'b1;
        end
    end

    // LFSR presents its current value during a RANDOM cycle and steps at its end,
    // so the first random sample is SEED itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               lfsr <= SEED;
        else if (accept)          lfsr <= SEED;
        else if (state == RANDOM) lfsr <= lfsr_step(lfsr);
    end

    // x_valid delayed by DUT_LATENCY marks the cycles in which y_in answers a stimulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cap_sr <= '0;
        else if (accept) cap_sr <= '0;
        else             cap_sr <= (cap_sr << 1) | LAT'(x_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature     <= '0;
            capture_count <= '0;
        end else if (accept) begin
            signature     <= '0;
            capture_count <= '0;
        end else if (cap_en) begin
            signature     <= {signature[30:0], signature[31]} ^ {{16{y_in[15]}}, y_in};
            capture_count <= capture_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
module tb_fir_stim_gen;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] x_out;
    logic               x_valid;
    logic signed [15:0] y_in = '0;
    logic               busy;
    logic               done;
    logic [31:0]        signature;
    logic [7:0]         capture_count;

    fir_stim_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .x_out         (x_out),
        .x_valid       (x_valid),
        .y_in          (y_in),
        .busy          (busy),
        .done          (done),
        .signature     (signature),
        .capture_count (capture_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct { int cyc; logic [15:0] val; } xexp_t;
    typedef struct { int cyc; logic [31:0] sig; logic [7:0] cnt; } dexp_t;

    xexp_t xq[$];
    dexp_t dq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-derived first random samples from seed 0xACE1.
    logic [15:0] rnd_hand [7] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C,
                                  16'h1C4E, 16'h0E27, 16'hB313};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Queue the expected samples of a run whose start was sampled at edge t0.
    // Samples after last_cyc are omitted (run cut short by reset).
    task automatic push_run(input int t0, input int last_cyc, input logic [31:0] sig);
        logic [15:0] r;
        logic [15:0] v;
        r = 16'h0;
        for (int c = 1; c <= 46; c++) begin
            if (c == 1)       v = 16'h4000;
            else if (c <= 16) v = 16'h0000;
            else begin
                if (c - 17 < 7) r = rnd_hand[c - 17];
                else            r = lfsr_model(r);
                v = r;
            end
            if (c <= last_cyc) xq.push_back('{t0 + c, v});
        end
        if (last_cyc >= 55) dq.push_back('{t0 + 55, sig, 8'd46});
    endtask

    task automatic start_run(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t0 = edge_cnt;
    endtask

    task automatic expect_drained(input string name);
        if (xq.size() != 0 || dq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d samples and %0d done pulses still outstanding, required 0",
                     name, xq.size(), dq.size());
            xq.delete();
            dq.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_x_out"},   {16'h0, x_out}, 32'h0);
        check({name, "_x_valid"}, 32'(x_valid), 32'h0);
        check({name, "_busy"},    32'(busy), 32'h0);
        check({name, "_done"},    32'(done), 32'h0);
    endtask

    // Monitor: compares every presented sample and done pulse against the scoreboard.
    always @(negedge clk) begin
        xexp_t xe;
        dexp_t de;
        if (x_valid === 1'b1) begin
            if (xq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL x_unexpected: x_valid=1 x_out=0x%04h at edge %0d, required no sample", x_out, edge_cnt);
            end else begin
                xe = xq.pop_front();
                check("x_cycle", edge_cnt, xe.cyc);
                check("x_out", {16'h0, x_out}, {16'h0, xe.val});
                check("busy_with_x", 32'(busy), 32'h1);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: done=1 at edge %0d, required 0", edge_cnt);
            end else begin
                de = dq.pop_front();
                check("done_cycle", edge_cnt, de.cyc);
                check("signature", signature, de.sig);
                check("capture_count", 32'(capture_count), 32'(de.cnt));
                check("busy_at_done", 32'(busy), 32'h0);
            end
        end
    end

    initial begin
        int t0;
        int t1;

        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        check("in_reset_sig", signature, 32'h0);
        check("in_reset_cnt", 32'(capture_count), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_quiet("after_reset");
        check("after_reset_sig", signature, 32'h0);

        // Run A: y_in = 0, stray start pulse in cycle 20 must be ignored.
        y_in = 16'sd0;
        start_run(t0);
        push_run(t0, 99, 32'h0000_0000);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        expect_drained("run_a_timeout");
        check_quiet("idle_after_a");

        // Run B: y_in = +1; result must hold after done.
        y_in = 16'sd1;
        start_run(t0);
        push_run(t0, 99, 32'hFFFF_C000);
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
        expect_drained("run_b_timeout");
        check("sig_hold", signature, 32'hFFFF_C000);
        check("cnt_hold", 32'(capture_count), 32'd46);

        // Runs C/D: y_in = -1 (sign extension cancels pairwise), start held high.
        y_in = -16'sd1;
        start_run(t0);
        push_run(t0, 99, 32'h0000_0000);
        repeat (56) @(posedge clk);
        t1 = edge_cnt;
        check("restart_edge", t1 - t0, 32'd56);
        push_run(t1, 99, 32'h0000_0000);
        @(negedge clk);
        start = 1'b0;
        repeat (65) @(negedge clk);
        expect_drained("run_cd_timeout");

        // Reset mid-run in cycle 30, then a clean run from SEED.
        y_in = 16'sd1;
        start_run(t0);
        push_run(t0, 29, 32'h0);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        check("mid_reset_sig", signature, 32'h0);
        check("mid_reset_cnt", 32'(capture_count), 32'h0);
        expect_drained("mid_reset_pending");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("post_mid_reset");
        start_run(t0);
        push_run(t0, 99, 32'hFFFF_C000);
        @(negedge clk);
        start = 1'b0;
        repeat (65) @(negedge clk);
        expect_drained("run_e_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
